// File: rtl/store_serializer.sv
// Narrows a register value to STUR/STURW/STURH/STURB size and writes the kept
// bytes little-endian, one byte per accepted beat, flagging lossy truncation.
module store_serializer #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 64,
    parameter int SIGNED     = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_data,
    input  logic [1:0]            req_size,
    output logic                  mem_wr_en,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [7:0]            mem_wdata,
    input  logic                  mem_ready,
    output logic                  done,
    output logic                  trunc_flag
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // Re-extend the kept part; any difference means significant bits were dropped.
    function automatic logic trunc_check(input logic [DATA_WIDTH-1:0] d,
                                         input logic [1:0]            sz);
        logic [DATA_WIDTH-1:0] ext;
        ext = d;
        case (sz)
            2'd0: ext = (SIGNED != 0) ? {{(DATA_WIDTH-8){d[7]}}, d[7:0]}
                                      : {{(DATA_WIDTH-8){1'b0}}, d[7:0]};
            2'd1: ext = (SIGNED != 0) ? {{(DATA_WIDTH-16){d[15]}}, d[15:0]}
                                      : {{(DATA_WIDTH-16){1'b0}}, d[15:0]};
            2'd2: ext = (SIGNED != 0) ? {{(DATA_WIDTH-32){d[31]}}, d[31:0]}
                                      : {{(DATA_WIDTH-32){1'b0}}, d[31:0]};
            2'd3: ext = d;
            default: ext = d;
        endcase
        return (ext != d);
    endfunction

    state_t                state_r, state_s;
    logic [2:0]            cnt_r, cnt_s;
    logic [2:0]            cnt_inc_s;
    logic                  last_s;
    logic [ADDR_WIDTH-1:0] base_r, base_s;
    logic [DATA_WIDTH-1:0] data_r, data_s;
    logic [1:0]            size_r, size_s;
    logic                  trunc_pend_r, trunc_pend_s;
    logic                  req_ready_r, req_ready_s;
    logic                  mem_wr_en_r, mem_wr_en_s;
    logic [ADDR_WIDTH-1:0] mem_addr_r, mem_addr_s;
    logic [7:0]            mem_wdata_r, mem_wdata_s;
    logic                  done_r, done_s;
    logic                  trunc_flag_r, trunc_flag_s;

    // Last beat index is N-1; the 3-bit wrap makes size 3 yield 7.
    assign cnt_inc_s = cnt_r + 3'd1;
    assign last_s    = (cnt_r == ((3'd1 << size_r) - 3'd1));

    // Next-state and next-output decode; outputs are registered one cycle ahead.
    always_comb begin
        state_s      = state_r;
        cnt_s        = cnt_r;
        base_s       = base_r;
        data_s       = data_r;
        size_s       = size_r;
        trunc_pend_s = trunc_pend_r;
        req_ready_s  = req_ready_r;
        mem_wr_en_s  = mem_wr_en_r;
        mem_addr_s   = mem_addr_r;
        mem_wdata_s  = mem_wdata_r;
        done_s       = 1'b0;
        trunc_flag_s = trunc_flag_r;
        case (state_r)
            ST_IDLE: begin
                if (req_valid && req_ready_r) begin
                    state_s      = ST_WRITE;
                    cnt_s        = 3'd0;
                    base_s       = req_addr;
                    data_s       = req_data;
                    size_s       = req_size;
                    trunc_pend_s = trunc_check(req_data, req_size);
                    req_ready_s  = 1'b0;
                    mem_wr_en_s  = 1'b1;
                    mem_addr_s   = req_addr;
                    mem_wdata_s  = req_data[7:0];
                end else begin
                    req_ready_s = 1'b1;
                    mem_wr_en_s = 1'b0;
                end
            end
            ST_WRITE: begin
                // A stalled beat keeps address and data exactly as presented.
                if (mem_ready) begin
                    if (last_s) begin
                        state_s      = ST_DONE;
                        mem_wr_en_s  = 1'b0;
                        mem_addr_s   = {ADDR_WIDTH{1'b0}};
                        mem_wdata_s  = 8'd0;
                        done_s       = 1'b1;
                        trunc_flag_s = trunc_pend_r;
                    end else begin
                        cnt_s       = cnt_inc_s;
                        mem_addr_s  = base_r + ADDR_WIDTH'(cnt_inc_s);
                        mem_wdata_s = data_r[{cnt_inc_s, 3'b000} +: 8];
                    end
                end else begin
                    mem_wr_en_s = 1'b1;
                end
            end
            ST_DONE: begin
                state_s     = ST_IDLE;
                req_ready_s = 1'b1;
                mem_wr_en_s = 1'b0;
            end
            default: begin
                state_s     = ST_IDLE;
                cnt_s       = 3'd0;
                req_ready_s = 1'b1;
                mem_wr_en_s = 1'b0;
                mem_addr_s  = {ADDR_WIDTH{1'b0}};
                mem_wdata_s = 8'd0;
            end
        endcase
    end

    // State, captured request and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            cnt_r        <= 3'd0;
            base_r       <= {ADDR_WIDTH{1'b0}};
            data_r       <= {DATA_WIDTH{1'b0}};
            size_r       <= 2'd0;
            trunc_pend_r <= 1'b0;
            req_ready_r  <= 1'b1;
            mem_wr_en_r  <= 1'b0;
            mem_addr_r   <= {ADDR_WIDTH{1'b0}};
            mem_wdata_r  <= 8'd0;
            done_r       <= 1'b0;
            trunc_flag_r <= 1'b0;
        end else begin
            state_r      <= state_s;
            cnt_r        <= cnt_s;
            base_r       <= base_s;
            data_r       <= data_s;
            size_r       <= size_s;
            trunc_pend_r <= trunc_pend_s;
            req_ready_r  <= req_ready_s;
            mem_wr_en_r  <= mem_wr_en_s;
            mem_addr_r   <= mem_addr_s;
            mem_wdata_r  <= mem_wdata_s;
            done_r       <= done_s;
            trunc_flag_r <= trunc_flag_s;
        end
    end

    assign req_ready  = req_ready_r;
    assign mem_wr_en  = mem_wr_en_r;
    assign mem_addr   = mem_addr_r;
    assign mem_wdata  = mem_wdata_r;
    assign done       = done_r;
    assign trunc_flag = trunc_flag_r;

endmodule

// File: tb/tb_store_serializer.sv
// Bench for store_serializer: vector table plus hand sequences; a beat
// scoreboard compares every presented memory beat against expected order.
module tb_store_serializer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready, req_ready_u;
    logic [63:0] req_addr;
    logic [63:0] req_data;
    logic [1:0]  req_size;
    logic        mem_wr_en, mem_wr_en_u;
    logic [63:0] mem_addr, mem_addr_u;
    logic [7:0]  mem_wdata, mem_wdata_u;
    logic        mem_ready;
    logic        done, done_u;
    logic        trunc_flag, trunc_flag_u;

    always #5 clk = ~clk;

    store_serializer #(.DATA_WIDTH(64), .ADDR_WIDTH(64), .SIGNED(1)) u_dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_data(req_data), .req_size(req_size),
        .mem_wr_en(mem_wr_en), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ready(mem_ready), .done(done), .trunc_flag(trunc_flag)
    );

    store_serializer #(.DATA_WIDTH(64), .ADDR_WIDTH(64), .SIGNED(0)) u_dut_u (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready_u),
        .req_addr(req_addr), .req_data(req_data), .req_size(req_size),
        .mem_wr_en(mem_wr_en_u), .mem_addr(mem_addr_u), .mem_wdata(mem_wdata_u),
        .mem_ready(mem_ready), .done(done_u), .trunc_flag(trunc_flag_u)
    );

    typedef struct {
        logic [1:0]  size;
        logic [63:0] addr;
        logic [63:0] data;
        int          stalls;
        logic        ts;
        logic        tu;
    } vec_t;

    typedef struct {
        logic [63:0] addr;
        logic [7:0]  data;
    } beat_t;

    vec_t  vecs[8];
    beat_t exp_q[$];
    int    checks = 0;
    int    errors = 0;
    int    beats  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_beats(input int n, input logic [63:0] addr, input logic [63:0] data);
        for (int i = 0; i < n; i++) begin
            beat_t b;
            b.addr = addr + 64'(i);
            b.data = 8'(data >> (8 * i));
            exp_q.push_back(b);
        end
    endtask

    // Scoreboard: every presented beat must match the head; accepted ones are popped.
    always @(negedge clk) begin
        if (rst_n && mem_wr_en) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_beat: got addr 0x%0h data 0x%0h, none expected", mem_addr, mem_wdata);
            end else begin
                chk("beat_addr", mem_addr, exp_q[0].addr);
                chk("beat_data", {56'd0, mem_wdata}, {56'd0, exp_q[0].data});
                if (mem_ready) begin
                    void'(exp_q.pop_front());
                    beats++;
                end
            end
        end
    end

    task automatic run_vec(input vec_t v);
        int cyc;
        int b0;
        bit seen;
        @(posedge clk); #1;
        chk("req_ready_idle", {63'd0, req_ready}, 64'd1);
        req_valid = 1'b1;
        req_size  = v.size;
        req_addr  = v.addr;
        req_data  = v.data;
        push_beats(1 << v.size, v.addr, v.data);
        b0 = beats;
        @(posedge clk); #1;
        req_valid = 1'b0;
        cyc  = 1;
        seen = 1'b0;
        while (!seen && cyc < 200) begin
            mem_ready = (cyc > v.stalls);
            if (done) begin
                seen = 1'b1;
            end else begin
                @(posedge clk); #1;
                cyc++;
            end
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: got no done after %0d cycles, required done", cyc);
        end
        chk("done_cycle", 64'(cyc), 64'((1 << v.size) + 1 + v.stalls));
        chk("trunc_signed", {63'd0, trunc_flag}, {63'd0, v.ts});
        chk("trunc_unsigned", {63'd0, trunc_flag_u}, {63'd0, v.tu});
        chk("beat_count", 64'(beats - b0), 64'(1 << v.size));
        chk("wr_en_in_done", {63'd0, mem_wr_en}, 64'd0);
        chk("ready_in_done", {63'd0, req_ready}, 64'd0);
        @(posedge clk); #1;
        chk("req_ready_return", {63'd0, req_ready}, 64'd1);
        chk("done_one_cycle", {63'd0, done}, 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int b0;
        vecs[0] = '{2'd0, 64'h100, 64'hFFFF_FFFF_FFFF_FF80, 0, 1'b0, 1'b1};
        vecs[1] = '{2'd0, 64'h100, 64'h0000_0000_0000_0080, 0, 1'b1, 1'b0};
        vecs[2] = '{2'd3, 64'h2000, 64'h0123_4567_89AB_CDEF, 0, 1'b0, 1'b0};
        vecs[3] = '{2'd2, 64'hFFFF_FFFF_FFFF_FFFE, 64'h0000_0000_DEAD_BEEF, 0, 1'b1, 1'b0};
        vecs[4] = '{2'd1, 64'h10, 64'h0000_0000_0000_1234, 3, 1'b0, 1'b0};
        vecs[5] = '{2'd1, 64'h7, 64'hFFFF_FFFF_FFFF_8001, 0, 1'b0, 1'b1};
        vecs[6] = '{2'd2, 64'h3, 64'h0000_0001_0000_0000, 1, 1'b1, 1'b1};
        vecs[7] = '{2'd1, 64'h21, 64'h0000_0000_0000_7FFF, 0, 1'b0, 1'b0};

        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_addr  = 64'd0;
        req_data  = 64'd0;
        req_size  = 2'd0;
        mem_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rst_req_ready", {63'd0, req_ready}, 64'd1);
        chk("rst_mem_wr_en", {63'd0, mem_wr_en}, 64'd0);
        chk("rst_done", {63'd0, done}, 64'd0);
        chk("rst_trunc_flag", {63'd0, trunc_flag}, 64'd0);
        chk("rst_mem_addr", mem_addr, 64'd0);
        chk("rst_mem_wdata", {56'd0, mem_wdata}, 64'd0);

        for (int i = 0; i < 8; i++) begin
            run_vec(vecs[i]);
        end

        // Back-to-back: B is held valid while A is busy and waits for req_ready.
        @(posedge clk); #1;
        chk("b2b_ready_a", {63'd0, req_ready}, 64'd1);
        req_valid = 1'b1;
        req_size  = 2'd1;
        req_addr  = 64'h40;
        req_data  = 64'h0000_0000_0000_8000;
        push_beats(2, 64'h40, 64'h8000);
        push_beats(1, 64'h50, 64'h05);
        @(posedge clk); #1;
        req_size = 2'd0;
        req_addr = 64'h50;
        req_data = 64'h05;
        @(posedge clk); #1;
        chk("b2b_busy_ready", {63'd0, req_ready}, 64'd0);
        @(posedge clk); #1;
        chk("b2b_done_a", {63'd0, done}, 64'd1);
        chk("b2b_trunc_a", {63'd0, trunc_flag}, 64'd1);
        chk("b2b_trunc_a_u", {63'd0, trunc_flag_u}, 64'd0);
        @(posedge clk); #1;
        chk("b2b_ready_b", {63'd0, req_ready}, 64'd1);
        chk("b2b_no_done", {63'd0, done}, 64'd0);
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("b2b_b_addr", mem_addr, 64'h50);
        chk("b2b_trunc_hold", {63'd0, trunc_flag}, 64'd1);
        @(posedge clk); #1;
        chk("b2b_done_b", {63'd0, done}, 64'd1);
        chk("b2b_trunc_b", {63'd0, trunc_flag}, 64'd0);
        chk("b2b_queue_empty", 64'(exp_q.size()), 64'd0);
        @(posedge clk); #1;

        // Reset in the middle of a dword store: beats stop without a clock edge.
        req_valid = 1'b1;
        req_size  = 2'd3;
        req_addr  = 64'h3000;
        req_data  = 64'h1122_3344_5566_7788;
        push_beats(3, 64'h3000, 64'h1122_3344_5566_7788);
        b0 = beats;
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        chk("pre_rst_wr_en", {63'd0, mem_wr_en}, 64'd1);
        rst_n = 1'b0;
        #1;
        chk("rst_async_wr_en", {63'd0, mem_wr_en}, 64'd0);
        chk("rst_async_ready", {63'd0, req_ready}, 64'd1);
        chk("rst_beats_before", 64'(beats - b0), 64'd3);
        exp_q.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("post_rst_wr_en", {63'd0, mem_wr_en}, 64'd0);
        chk("post_rst_trunc", {63'd0, trunc_flag}, 64'd0);
        chk("final_queue_empty", 64'(exp_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
